// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Contents: XLEN_DEF (default register width), ZERO_REG (hard-wired zero
// register index), addr_width() (address width for a register count).
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ZERO_REG = 0;

  // Smallest address width that can index n registers, and never below 1.
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for register_file_mp.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_we/rd_addr       write ports; a write retires its register's producer
//   iss_valid/iss_rd    issue reserving a destination register
//   flush               drop every pending reservation
//   rs_addr             read-port addresses to look up
//   rs_busy             busy bit per read port (0 for x0 / out-of-range)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NWR-1:0]                rd_we,
  input  logic [NWR-1:0][AW-1:0]        rd_addr,
  input  logic                          iss_valid,
  input  logic [AW-1:0]                 iss_rd,
  input  logic                          flush,
  input  logic [NRD-1:0][AW-1:0]        rs_addr,
  output logic [NRD-1:0]                rs_busy
);
  logic [NREGS-1:0] busy, busy_nxt;

  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  // Clears are applied before the set so a same-cycle reissue keeps the
  // register busy for the newer producer; flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (rd_we[j] && valid_addr(rd_addr[j])) busy_nxt[rd_addr[j]] = 1'b0;
      if (iss_valid && valid_addr(iss_rd)) busy_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < NRD; i++)
      if (valid_addr(rs_addr[i])) rs_busy[i] = busy[rs_addr[i]];
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with issue scoreboard.
// Combinational reads, x0 hard-wired to zero, out-of-range addresses read
// 0 and ignore writes/issues; highest-index write port wins on conflict.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rs_addr/rs_data/rs_busy  NRD read ports (flat, port i in slice i)
//   rd_we/rd_addr/rd_data    NWR write ports (flat)
//   iss_valid/iss_rd         destination reservation at issue
//   flush                    clear all reservations
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writes to
// the read ports (data and busy); otherwise reads see the write next cycle.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = 32,
  parameter int  NRD   = 2,
  parameter int  NWR   = 2,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      rd_we,
  input  logic [NWR*AW-1:0]   rd_addr,
  input  logic [NWR*XLEN-1:0] rd_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush
);
  logic [NRD-1:0][AW-1:0]   ra;
  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;
  logic [NRD-1:0][XLEN-1:0] rdat;
  logic [NRD-1:0]           sb_busy;
  logic [XLEN-1:0]          regs [NREGS];

  assign ra = rs_addr;
  assign wa = rd_addr;
  assign wd = rd_data;
  assign rs_data = rdat;

  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  // One flop row per register; later ports overwrite earlier ones so the
  // highest-index port wins. Row 0 only ever holds its reset value.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regs[r] <= '0;
      end else if (r != ZERO_REG) begin
        for (int j = 0; j < NWR; j++)
          if (rd_we[j] && wa[j] == AW'(r)) regs[r] <= wd[j];
      end
    end
  end

  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR), .AW(AW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_we     (rd_we),
    .rd_addr   (wa),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .rs_addr   (ra),
    .rs_busy   (sb_busy)
  );

`ifdef REGFILE_BYPASS_EN
  logic [NRD-1:0] byp_hit;

  always_comb begin
    rdat    = '0;
    byp_hit = '0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!rst && valid_addr(ra[i])) begin
        rdat[i] = regs[ra[i]];
        for (int j = 0; j < NWR; j++)
          if (rd_we[j] && wa[j] == ra[i]) begin
            rdat[i]    = wd[j];
            byp_hit[i] = 1'b1;
          end
        // A forwarded write retires the producer unless a new one is
        // issuing to the same register this cycle.
        rs_busy[i] = byp_hit[i] ? (iss_valid && !flush && iss_rd == ra[i])
                                : sb_busy[i];
      end
    end
  end
`else
  always_comb begin
    rdat    = '0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++)
      if (!rst && valid_addr(ra[i])) begin
        rdat[i]    = regs[ra[i]];
        rs_busy[i] = sb_busy[i];
      end
  end
`endif
endmodule
